// File: rtl/rr_slot_arbiter_pkg.sv
// Package: arb_pkg
// Purpose: shared types and width helper for the round-robin slot arbiter.
//   arb_state_e - arbiter FSM state encoding (IDLE, GRANT)
//   idx_w()     - bit width needed to index n values (at least 1)
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_slot_arbiter_if.sv
// Interface: rr_slot_arbiter_if
// Purpose: bundles the requester-side and status signals of the arbiter.
//   en      requester -> arbiter  arbitration enable
//   req     requester -> arbiter  per-requester request level
//   done    requester -> arbiter  per-requester release pulse
//   gnt     arbiter -> requester  one-hot grant
//   gnt_id  arbiter -> requester  index of granted requester
//   busy    arbiter -> requester  grant active
//   ptr     arbiter -> requester  round-robin pointer
//   timeout arbiter -> requester  hold-limit revocation pulse
// Modports: master = requester/resource side, slave = arbiter.
interface rr_slot_arbiter_if #(
  parameter int unsigned N = 4
);
  import arb_pkg::*;

  localparam int unsigned IW = idx_w(N);

  logic          en;
  logic [N-1:0]  req;
  logic [N-1:0]  done;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          busy;
  logic [IW-1:0] ptr;
  logic          timeout;

  modport master (
    output en, req, done,
    input  gnt, gnt_id, busy, ptr, timeout
  );

  modport slave (
    input  en, req, done,
    output gnt, gnt_id, busy, ptr, timeout
  );

endinterface

// File: rtl/rr_slot_arbiter_ptr.sv
// Module: mod_n_ptr
// Purpose: modulo-N pointer register. On advance it loads load_val+1,
//   wrapping N-1 back to 0, so values >= N are never produced.
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset (pointer -> 0)
//   advance  in   load the successor of load_val this cycle
//   load_val in   index whose successor becomes the new pointer
//   ptr      out  current pointer
module mod_n_ptr #(
  parameter int unsigned N = 4,
  parameter int unsigned W = arb_pkg::idx_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         advance,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (load_val >= W'(N - 1)) ? '0 : load_val + W'(1);
    end
  end

endmodule

// File: rtl/rr_slot_arbiter.sv
// Module: rr_slot_arbiter
// Purpose: round-robin arbiter sharing one resource between N requesters.
//   A grant is held until the owner pulses done, drops its request, or has
//   held it for MAX_HOLD cycles; the pointer then moves past the winner.
//   clk  in     rising-edge clock
//   rst  in     asynchronous active-high reset
//   bus  slave  en/req/done in; gnt/gnt_id/busy/ptr/timeout out (registered)
//
// state | meaning
// IDLE  | no grant; pick next requester from ptr when en and any req
// GRANT | one requester owns the resource; hold counter running
module rr_slot_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  rr_slot_arbiter_if.slave   bus
);

  localparam int unsigned IW = idx_w(N);
  localparam int unsigned HW = idx_w(MAX_HOLD + 1);

  arb_state_e    state;
  logic [HW-1:0] hold_cnt;

  // Round-robin pick: rotate req so ptr sits at bit 0, take the lowest set
  // bit, then add ptr back modulo N.
  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [IW-1:0]  off;
  logic           found;
  logic [IW:0]    sum;
  logic [IW-1:0]  pick_id;

  always_comb begin
    req_dbl = {bus.req, bus.req};
    req_rot = N'(req_dbl >> bus.ptr);
    off     = '0;
    found   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        off   = IW'(i);
        found = 1'b1;
      end
    end
    sum     = {1'b0, bus.ptr} + {1'b0, off};
    pick_id = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : IW'(sum);
  end

  logic rel_done;
  logic rel_drop;
  logic rel_hold;
  logic release_now;

  always_comb begin
    rel_done    = bus.done[bus.gnt_id];
    rel_drop    = !bus.req[bus.gnt_id];
    rel_hold    = (hold_cnt == HW'(MAX_HOLD - 1));
    release_now = (state == GRANT) && (rel_done || rel_drop || rel_hold);
  end

  mod_n_ptr #(
    .N (N),
    .W (IW)
  ) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .advance  (release_now),
    .load_val (bus.gnt_id),
    .ptr      (bus.ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      bus.gnt     <= '0;
      bus.gnt_id  <= '0;
      bus.busy    <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en && found) begin
            bus.gnt    <= N'(1) << pick_id;
            bus.gnt_id <= pick_id;
            bus.busy   <= 1'b1;
            hold_cnt   <= '0;
            state      <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            bus.gnt     <= '0;
            bus.busy    <= 1'b0;
            // Only flag a revocation the owner did not ask for itself.
            bus.timeout <= rel_hold && !rel_done && !rel_drop;
            state       <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
